pe_acc_sequencer: RTL and testbench
===================================

// Module: pe_acc_sequencer
// PURPOSE
//  Sequences one accumulation tile through the PE front pipeline (fetch stage -> multiply stage).
//  Accepts one tile config over a rdy/ack slave port, then emits one control token per pipeline
//  beat on a rdy/ack master port. Token fields: psum mode/parity, accumulate first/last, tap and
//  channel-group indices. Sits between the PE tile controller and the fetch-stage control input.
// PARAMETERS
//  KW     4   width of tap count/index (max taps 2**KW-1)
//  CW     6   width of channel-group count/index (max groups 2**CW-1)
// PORTS
//  i_clk       in   1    clock
//  i_rst       in   1    asynchronous reset, active low
//  cfg_rdy     in   1    config valid (sender side of rdy/ack)
//  cfg_ack     out  1    config accepted
//  i_cfg       in   AccCfg  {n_tap[KW], n_grp[CW], psum_mode(D8/D16)}
//  ctl_rdy     out  1    token valid toward fetch stage
//  ctl_ack     in   1    token accepted by fetch stage
//  o_ctl       out  AccTok  {psum_mode, psum_parity, acc_first, acc_last, tap[KW], grp[CW]}
//  o_busy      out  1    tile in progress (state != IDLE)
//  o_done      out  1    one-cycle pulse after final token transfer
// BEHAVIOUR
//  - One clock, i_rst asynchronous active-low. In reset: state=IDLE, cfg_ack=0, ctl_rdy=0,
//    o_ctl='0, o_busy=0, o_done=0, all counters 0.
//  - Transfer on either port occurs in the cycle where rdy && ack. ctl_rdy, once high, stays high
//    and o_ctl stays stable until ctl_ack; no retraction.
//  - FSM: IDLE -> (cfg_rdy) LOAD -> RUN -> DONE -> IDLE.
//    IDLE: cfg_ack=1 combinationally with cfg_rdy; config registered on transfer.
//    LOAD: one cycle; if n_tap==0 or n_grp==0 go DONE with no tokens, else preset counters, RUN.
//    RUN: ctl_rdy=1; on each transfer advance the counters.
//      Innermost: parity (D16 only: 0 then 1). Then tap 0..n_tap-1. Then grp 0..n_grp-1.
//      After the last transfer go DONE.
//    DONE: o_done=1 for exactly one cycle, then IDLE. cfg_ack=0 in LOAD/RUN/DONE.
//  - Token count = n_tap*n_grp*(psum_mode==D16 ? 2 : 1).
//    psum_parity=0 always in D8 mode; in D16 mode it toggles every token.
//  - acc_first=1 on tokens with tap==0 (zero-init psum).
//    acc_last=1 on tokens with tap==n_tap-1 (write-back).
//    Both are 1 when n_tap==1. In D16 mode both parities of the qualifying tap carry the flag.
//  - First token appears 2 cycles after cfg transfer (LOAD, then RUN register).
//    Full throughput: one token per cycle while ctl_ack=1.
//  - Counter wrap: tap wraps to 0 and grp increments in the same cycle. No counter exceeds its
//    configured count minus one.
//  - ctl_ack low in RUN: hold all state and o_ctl. ctl_ack while ctl_rdy=0 is ignored.
//  - cfg_rdy outside IDLE is ignored (not acked, not sampled).
//  - Reset mid-tile: everything returns to reset values immediately. The partial tile is dropped
//    and no o_done is produced.
// STRUCTURE
//  - AccCfg, AccTok typedefs and the D8/D16 psum-mode enum go in PECtlCfg. Reuse the existing
//    psum_mode type there.
//  - One sub-module: acc_idx_counter, a nested parity/tap/grp counter with enable, load,
//    wrap and last outputs.
//  - FSM and handshake logic stay in this module.
// TESTING
//  1. n_tap=3, n_grp=2, D8, ctl_ack=1 -> 6 tokens back-to-back; tap 0,1,2,0,1,2; grp 0,0,0,1,1,1;
//     first on taps 0, last on taps 2; parity always 0; o_done 1 cycle after 6th transfer.
//  2. n_tap=2, n_grp=1, D16 -> 4 tokens; parity 0,1,0,1; tap 0,0,1,1; first=1,1,0,0; last=0,0,1,1.
//  3. Case 1 with ctl_ack toggled randomly -> o_ctl stable during stalls; identical token
//     sequence; o_busy=1 throughout.
//  4. n_tap=0, n_grp=5 -> no ctl_rdy ever; o_done pulses 2 cycles after cfg transfer;
//     next cfg acked in IDLE.
//  5. cfg_rdy held high during RUN -> cfg_ack=0 until IDLE, then exactly one further tile runs.
//  6. n_tap=15, n_grp=63, D16 with reset asserted after 100 transfers -> outputs zero
//     asynchronously; no o_done; fresh cfg after release starts tap=0, grp=0, parity=0.

Source files
------------

// File: rtl/pe_acc_sequencer_pkg.sv
// Shared types for the PE accumulation sequencer: tile config, control token, psum mode.
// Index widths live here so every block that carries a token agrees on its layout.
package PECtlCfg;

  localparam int KW = 4;
  localparam int CW = 6;

  typedef enum logic {
    PSUM_D8  = 1'b0,
    PSUM_D16 = 1'b1
  } psum_mode_t;

  typedef struct packed {
    logic [KW-1:0] n_tap;
    logic [CW-1:0] n_grp;
    psum_mode_t    psum_mode;
  } AccCfg;

  typedef struct packed {
    psum_mode_t    psum_mode;
    logic          psum_parity;
    logic          acc_first;
    logic          acc_last;
    logic [KW-1:0] tap;
    logic [CW-1:0] grp;
  } AccTok;

  // The first/last flags depend only on the tap, so both D16 parities of a tap share them.
  function automatic AccTok makeTok(input AccCfg cfg, input logic parity,
                                    input logic [KW-1:0] tap, input logic [CW-1:0] grp);
    AccTok tok;
    tok.psum_mode   = cfg.psum_mode;
    tok.psum_parity = parity;
    tok.acc_first   = (tap == '0);
    tok.acc_last    = (tap == cfg.n_tap - KW'(1));
    tok.tap         = tap;
    tok.grp         = grp;
    return tok;
  endfunction

endpackage

// File: rtl/pe_acc_sequencer_idx.sv
// Nested parity/tap/grp index counter for one accumulation tile.
// Exposes the index that follows the current one, so the owner can register tokens directly.
module acc_idx_counter #(
  parameter int KW = 4,
  parameter int CW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic          d16_i,
  input  logic [KW-1:0] n_tap_i,
  input  logic [CW-1:0] n_grp_i,
  output logic          nxt_parity_o,
  output logic [KW-1:0] nxt_tap_o,
  output logic [CW-1:0] nxt_grp_o,
  output logic          last_o
);

  logic          parity_q;
  logic [KW-1:0] tap_q;
  logic [CW-1:0] grp_q;
  logic          parWrap;
  logic          tapWrap;

  // In D8 the parity stage is transparent, so the tap advances on every step.
  always_comb begin
    parWrap      = ~d16_i | parity_q;
    tapWrap      = parWrap & (tap_q == n_tap_i - KW'(1));
    last_o       = tapWrap & (grp_q == n_grp_i - CW'(1));
    nxt_parity_o = d16_i & ~parity_q;
    nxt_tap_o    = tap_q;
    nxt_grp_o    = grp_q;
    if (parWrap) nxt_tap_o = tapWrap ? '0 : tap_q + KW'(1);
    if (tapWrap) nxt_grp_o = last_o ? '0 : grp_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      parity_q <= 1'b0;
      tap_q    <= '0;
      grp_q    <= '0;
    end else if (load_i) begin
      parity_q <= 1'b0;
      tap_q    <= '0;
      grp_q    <= '0;
    end else if (en_i) begin
      parity_q <= nxt_parity_o;
      tap_q    <= nxt_tap_o;
      grp_q    <= nxt_grp_o;
    end
  end

endmodule

// File: rtl/pe_acc_sequencer.sv
// Accepts one tile config and emits one control token per PE front-pipeline beat.
// Tokens, busy and done are all registered; only cfg_ack is combinational with cfg_rdy.
module pe_acc_sequencer
  import PECtlCfg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  cfg_rdy,
  output logic  cfg_ack,
  input  AccCfg i_cfg,
  output logic  ctl_rdy,
  input  logic  ctl_ack,
  output AccTok o_ctl,
  output logic  o_busy,
  output logic  o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  AccCfg         cfg_q;
  AccTok         ctl_q;
  logic          ctl_rdy_q;
  logic          busy_q;
  logic          done_q;
  logic          nxtParity;
  logic [KW-1:0] nxtTap;
  logic [CW-1:0] nxtGrp;
  logic          lastIdx;
  logic          ctlXfer;

  assign cfg_ack = (state_q == S_IDLE) & cfg_rdy;
  assign ctlXfer = (state_q == S_RUN) & ctl_rdy_q & ctl_ack;
  assign ctl_rdy = ctl_rdy_q;
  assign o_ctl   = ctl_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  acc_idx_counter #(.KW(KW), .CW(CW)) u_idx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .en_i         (ctlXfer),
    .load_i       (state_q == S_LOAD),
    .d16_i        (cfg_q.psum_mode == PSUM_D16),
    .n_tap_i      (cfg_q.n_tap),
    .n_grp_i      (cfg_q.n_grp),
    .nxt_parity_o (nxtParity),
    .nxt_tap_o    (nxtTap),
    .nxt_grp_o    (nxtGrp),
    .last_o       (lastIdx)
  );

  // The token register is preloaded in LOAD and advanced from the counter's next index
  // on each transfer, so o_ctl stays frozen while the fetch stage stalls.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      ctl_q     <= '0;
      ctl_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_rdy) begin
            cfg_q   <= i_cfg;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cfg_q.n_tap == '0 || cfg_q.n_grp == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ctl_q     <= makeTok(cfg_q, 1'b0, '0, '0);
            ctl_rdy_q <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (ctlXfer) begin
            if (lastIdx) begin
              ctl_q     <= '0;
              ctl_rdy_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              ctl_q <= makeTok(cfg_q, nxtParity, nxtTap, nxtGrp);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_acc_sequencer.sv
// Directed bench for pe_acc_sequencer: walks tiles and compares each token with a loop model.
module tb_pe_acc_sequencer;
  import PECtlCfg::*;

  logic  i_clk = 1'b0;
  logic  i_rst = 1'b0;
  logic  cfg_rdy = 1'b0;
  logic  cfg_ack;
  AccCfg i_cfg = '0;
  logic  ctl_rdy;
  logic  ctl_ack = 1'b0;
  AccTok o_ctl;
  logic  o_busy;
  logic  o_done;

  int checks = 0;
  int passes = 0;

  pe_acc_sequencer dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .cfg_rdy (cfg_rdy),
    .cfg_ack (cfg_ack),
    .i_cfg   (i_cfg),
    .ctl_rdy (ctl_rdy),
    .ctl_ack (ctl_ack),
    .o_ctl   (o_ctl),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Runs one tile. ackMode: 0 = always accept, 1 = random stalls. holdCfg keeps cfg_rdy high
  // throughout. abortAfter > 0 returns right after that many transfers, leaving the tile in RUN.
  task automatic applyStimulus(input int nTap, input int nGrp, input psum_mode_t mode,
                               input bit ackMode, input bit holdCfg, input int abortAfter);
    AccTok exp;
    int    nPar;
    int    xfers;
    int    stalls;
    bit    ack;
    bit    accepted;
    nPar  = (mode == PSUM_D16) ? 2 : 1;
    xfers = 0;
    cfg_rdy         = 1'b1;
    i_cfg.n_tap     = nTap[KW-1:0];
    i_cfg.n_grp     = nGrp[CW-1:0];
    i_cfg.psum_mode = mode;
    ctl_ack         = 1'b1;
    #1;
    checkOutput("cfg_ack_idle", cfg_ack, 1);
    tick();
    if (!holdCfg) cfg_rdy = 1'b0;
    checkOutput("load_rdy", ctl_rdy, 0);
    checkOutput("load_busy", o_busy, 1);
    checkOutput("load_cfg_ack", cfg_ack, 0);
    tick();
    if (nTap == 0 || nGrp == 0) begin
      checkOutput("empty_done", o_done, 1);
      checkOutput("empty_rdy", ctl_rdy, 0);
      tick();
      checkOutput("empty_done_end", o_done, 0);
      checkOutput("empty_busy_end", o_busy, 0);
      return;
    end
    for (int g = 0; g < nGrp; g++) begin
      for (int t = 0; t < nTap; t++) begin
        for (int p = 0; p < nPar; p++) begin
          exp.psum_mode   = mode;
          exp.psum_parity = p[0];
          exp.acc_first   = (t == 0);
          exp.acc_last    = (t == nTap - 1);
          exp.tap         = t[KW-1:0];
          exp.grp         = g[CW-1:0];
          stalls   = 0;
          accepted = 1'b0;
          while (!accepted) begin
            ack = ackMode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalls >= 6) ack = 1'b1;
            ctl_ack = ack;
            checkOutput("tok", o_ctl, exp);
            checkOutput("tok_rdy", ctl_rdy, 1);
            checkOutput("tok_busy", o_busy, 1);
            checkOutput("tok_cfg_ack", cfg_ack, 0);
            tick();
            if (ack) accepted = 1'b1;
            else stalls++;
          end
          xfers++;
          if (abortAfter > 0 && xfers == abortAfter) begin
            ctl_ack = 1'b0;
            return;
          end
        end
      end
    end
    ctl_ack = 1'b0;
    checkOutput("done_pulse", o_done, 1);
    checkOutput("done_rdy", ctl_rdy, 0);
    checkOutput("done_ctl", o_ctl, 0);
    checkOutput("done_cfg_ack", cfg_ack, 0);
    tick();
    checkOutput("done_end", o_done, 0);
    checkOutput("idle_busy", o_busy, 0);
    if (holdCfg) checkOutput("held_cfg_ack", cfg_ack, 1);
  endtask

  initial begin
    #2;
    checkOutput("rst_cfg_ack", cfg_ack, 0);
    checkOutput("rst_rdy", ctl_rdy, 0);
    checkOutput("rst_ctl", o_ctl, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    tick();
    i_rst = 1'b1;
    tick();

    $display("[TB] tile 3x2 D8 full rate");
    applyStimulus(3, 2, PSUM_D8, 1'b0, 1'b0, 0);
    $display("[TB] tile 2x1 D16");
    applyStimulus(2, 1, PSUM_D16, 1'b0, 1'b0, 0);
    $display("[TB] tile 3x2 D8 random stalls");
    applyStimulus(3, 2, PSUM_D8, 1'b1, 1'b0, 0);
    $display("[TB] empty tile then next cfg");
    applyStimulus(0, 5, PSUM_D8, 1'b0, 1'b0, 0);
    applyStimulus(1, 1, PSUM_D16, 1'b0, 1'b0, 0);

    $display("[TB] cfg_rdy held through a tile");
    applyStimulus(2, 2, PSUM_D8, 1'b0, 1'b1, 0);
    applyStimulus(1, 3, PSUM_D8, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_extra_busy", o_busy, 0);
      checkOutput("no_extra_rdy", ctl_rdy, 0);
    end

    $display("[TB] reset mid tile");
    applyStimulus(15, 63, PSUM_D16, 1'b0, 1'b0, 100);
    #2;
    i_rst = 1'b0;
    #1;
    checkOutput("abort_rdy", ctl_rdy, 0);
    checkOutput("abort_ctl", o_ctl, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_done", o_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_done", o_done, 0);
    end
    i_rst = 1'b1;
    tick();
    checkOutput("post_rst_done", o_done, 0);
    applyStimulus(2, 2, PSUM_D16, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
